parity_arbiter: RTL and testbench

PARITY_ARBITER -- requirements
Module: parity_arbiter

---
 rtl/parity_arbiter_pkg.sv | 19 +
 rtl/parity_nibble.sv | 9 +
 rtl/parity_arbiter.sv | 127 ++++++++++++
 tb/tb_parity_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_arbiter_pkg.sv
// Shared definitions for the parity arbiter: FSM state encodings, requester IDs
// and the round-robin grant rule.
package parity_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // On a tie the requester that did not own the previous frame wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_gnt);
    if (v0 && v1) rr_pick = ~last_gnt;
    else if (v0)  rr_pick = REQ_ID0;
    else          rr_pick = REQ_ID1;
  endfunction

endpackage

// File: rtl/parity_nibble.sv
// Even-parity reduction of one 4-bit nibble.
module parity_nibble (
  input  logic [3:0] nib_i,
  output logic       par_o
);

  assign par_o = ^nib_i;

endmodule

// File: rtl/parity_arbiter.sv
// Two-requester round-robin arbiter that accumulates the XOR parity and the
// nibble count of each granted frame and presents one result per frame.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_parity,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_parity_q, res_parity_d;
  logic             res_id_q, res_id_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic [3:0] gnt_data;
  logic       gnt_valid;
  logic       gnt_last;
  logic       beat;
  logic       nib_par;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign gnt_data  = (gnt_q == REQ_ID1) ? req1_data  : req0_data;
  assign gnt_valid = (gnt_q == REQ_ID1) ? req1_valid : req0_valid;
  assign gnt_last  = (gnt_q == REQ_ID1) ? req1_last  : req0_last;

  parity_nibble u_parity_nibble (
    .nib_i (gnt_data),
    .par_o (nib_par)
  );

  assign req0_ready = (state_q == ST_ACCUM) && (gnt_q == REQ_ID0);
  assign req1_ready = (state_q == ST_ACCUM) && (gnt_q == REQ_ID1);
  assign beat       = (state_q == ST_ACCUM) && gnt_valid;

  assign res_valid  = (state_q == ST_RESP);
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
  assign res_count  = res_count_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_parity_d = res_parity_q;
    res_id_d     = res_id_q;
    res_count_d  = res_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = rr_pick(req0_valid, req1_valid, last_gnt_q);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A stalled owner simply produces no beat; the frame waits indefinitely.
        if (beat) begin
          acc_d = acc_q ^ nib_par;
          cnt_d = sat_inc(cnt_q);
          if (gnt_last) begin
            state_d      = ST_RESP;
            res_parity_d = acc_q ^ nib_par;
            res_count_d  = sat_inc(cnt_q);
            res_id_d     = gnt_q;
          end
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d    = ST_IDLE;
          acc_d      = 1'b0;
          cnt_d      = '0;
          last_gnt_d = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= REQ_ID0;
      last_gnt_q   <= REQ_ID1;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      res_parity_q <= 1'b0;
      res_id_q     <= REQ_ID0;
      res_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_parity_q <= res_parity_d;
      res_id_q     <= res_id_d;
      res_count_q  <= res_count_d;
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Self-checking bench for parity_arbiter: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_parity_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0;
  logic [3:0] req0_data = 4'h0;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_last = 1'b0;
  logic [3:0] req1_data = 4'h0;
  logic       req1_ready;
  logic       res_valid, res_parity, res_id;
  logic [7:0] res_count;
  logic       res_ready = 1'b0;

  logic       s_req0_valid = 1'b0, s_req0_last = 1'b0;
  logic [3:0] s_req0_data = 4'h0;
  logic       s_req0_ready, s_req1_ready;
  logic       s_res_valid, s_res_parity, s_res_id;
  logic [1:0] s_res_count;
  logic       s_res_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int last_model = 1;

  always #5 clk = ~clk;

  parity_arbiter #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_parity(res_parity), .res_id(res_id), .res_count(res_count),
    .res_ready(res_ready)
  );

  parity_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_last(s_req0_last), .req0_ready(s_req0_ready),
    .req1_valid(1'b0), .req1_data(4'h0), .req1_last(1'b0), .req1_ready(s_req1_ready),
    .res_valid(s_res_valid), .res_parity(s_res_parity), .res_id(s_res_id), .res_count(s_res_count),
    .res_ready(s_res_ready)
  );

  function automatic int frame_parity(input int q[$]);
    int ones = 0;
    foreach (q[i]) for (int b = 0; b < 4; b++) ones += (q[i] >> b) & 1;
    return ones % 2;
  endfunction

  function automatic int exp_count(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = 4'h0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = 4'h0;
    res_ready = 1'b0;
    s_req0_valid = 1'b0; s_req0_last = 1'b0; s_req0_data = 4'h0; s_res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one nibble and wait (bounded) until it is accepted on a rising edge.
  task automatic drive_beat(input int id, input logic [3:0] d, input logic l);
    int   n;
    logic rdy;
    @(negedge clk);
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    else         begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    #1 rdy = (id == 0) ? req0_ready : req1_ready;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1 rdy = (id == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL beat_timeout req%0d: ready=%0b after %0d cycles, required 1", id, rdy, n);
    end
    @(posedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready}); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    tests++; if ({res_parity, res_id} !== 2'b00) begin fails++; $display("FAIL reset_res_bits: got %b required 00", {res_parity, res_id}); end
    tests++; if (res_count !== 8'd0) begin fails++; $display("FAIL reset_res_count: got %0d required 0", res_count); end
    tests++; if (s_res_count !== 2'd0 || s_res_valid !== 1'b0) begin fails++; $display("FAIL reset_sat: got cnt %0d valid %b required 0 0", s_res_count, s_res_valid); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 4'h3; req0_last = 1'b0;
    #1;
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL idle_no_ready: got %b required 0", req0_ready); end
    drive_beat(0, 4'h3, 1'b0);
    drive_beat(0, 4'h1, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: res_valid got %b required 1", res_valid); end
    tests++; if (res_parity !== 1'b1) begin fails++; $display("FAIL basic_parity: got %b required 1", res_parity); end
    tests++; if (res_count !== 8'd2) begin fails++; $display("FAIL basic_count: got %0d required 2", res_count); end
    tests++; if (res_id !== 1'b0) begin fails++; $display("FAIL basic_id: got %b required 0", res_id); end
    consume();
    #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL basic_release: res_valid got %b required 0", res_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 4'hF; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 4'hF; req1_last = 1'b1;
    @(negedge clk);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rr_first_grant: got %b required 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests++; if ({res_valid, res_id, res_parity} !== 3'b100 || res_count !== 8'd1) begin
      fails++; $display("FAIL rr_first_result: got valid/id/par %b count %0d required 100 count 1", {res_valid, res_id, res_parity}, res_count);
    end
    consume();
    @(negedge clk);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL rr_second_grant: got %b required 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    tests++; if ({res_valid, res_id, res_parity} !== 3'b110 || res_count !== 8'd1) begin
      fails++; $display("FAIL rr_second_result: got valid/id/par %b count %0d required 110 count 1", {res_valid, res_id, res_parity}, res_count);
    end
    consume();
  endtask

  task automatic test_gap();
    do_reset();
    drive_beat(1, 4'h7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_valid = 1'b0; req1_data = 4'($urandom); req1_last = 1'b1;
      #1;
      tests++; if (req1_ready !== 1'b1 || res_valid !== 1'b0) begin
        fails++; $display("FAIL gap_hold: ready1 %b res_valid %b required 1 0", req1_ready, res_valid);
      end
    end
    drive_beat(1, 4'h8, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    tests++; if (res_count !== 8'd2 || res_parity !== 1'b0 || res_id !== 1'b1) begin
      fails++; $display("FAIL gap_result: count %0d par %b id %b required 2 0 1", res_count, res_parity, res_id);
    end
    consume();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_beat(0, 4'h5, 1'b0);
    drive_beat(0, 4'hE, 1'b1);
    @(negedge clk);
    req0_data = 4'h0;
    req1_valid = 1'b1; req1_data = 4'h1; req1_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if ({res_valid, res_parity, res_id} !== 3'b110 || res_count !== 8'd2 || {req0_ready, req1_ready} !== 2'b00) begin
        fails++; $display("FAIL hold_stable cyc%0d: valid/par/id %b count %0d ready %b required 110 2 00", i, {res_valid, res_parity, res_id}, res_count, {req0_ready, req1_ready});
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL hold_next_grant: got %b required 01", {req0_ready, req1_ready}); end
    do_reset();
  endtask

  task automatic test_saturation();
    int q[$];
    int n;
    do_reset();
    q = {1, 1, 1, 1, 1};
    foreach (q[i]) begin
      @(negedge clk);
      s_req0_valid = 1'b1; s_req0_data = 4'(q[i]); s_req0_last = (i == q.size() - 1);
      n = 0;
      #1;
      while (!s_req0_ready && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
    end
    @(negedge clk);
    s_req0_valid = 1'b0;
    #1;
    tests++; if (s_res_valid !== 1'b1 || 32'(s_res_count) != exp_count(q.size(), 2)) begin
      fails++; $display("FAIL sat_count: valid %b count %0d required 1 %0d", s_res_valid, s_res_count, exp_count(q.size(), 2));
    end
    tests++; if (32'(s_res_parity) != frame_parity(q)) begin
      fails++; $display("FAIL sat_parity: got %b required %0d", s_res_parity, frame_parity(q));
    end
    @(negedge clk); s_res_ready = 1'b1;
    @(negedge clk); s_res_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive_beat(0, 4'h1, 1'b0);
    drive_beat(0, 4'h3, 1'b0);
    @(negedge clk);
    req0_data = 4'h7;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (res_valid !== 1'b0 || req0_ready !== 1'b0) begin
        fails++; $display("FAIL rst_discard cyc%0d: res_valid %b ready0 %b required 0 0", i, res_valid, req0_ready);
      end
      @(negedge clk);
    end
    drive_beat(0, 4'h1, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests++; if (res_count !== 8'd1 || res_parity !== 1'b1) begin
      fails++; $display("FAIL rst_fresh_frame: count %0d par %b required 1 1", res_count, res_parity);
    end
    consume();
    drive_beat(1, 4'h2, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_in_resp: res_valid got %b required 0", res_valid); end
  endtask

  task automatic test_random();
    do_reset();
    last_model = 1;
    for (int r = 0; r < 25; r++) begin
      int q0[$];
      int q1[$];
      int order[$];
      int mask, idx0, idx1, cyc, own, len, first;
      mask = $urandom_range(1, 3);
      if ((mask & 1) != 0) begin len = $urandom_range(1, 6); for (int i = 0; i < len; i++) q0.push_back($urandom_range(0, 15)); end
      if ((mask & 2) != 0) begin len = $urandom_range(1, 6); for (int i = 0; i < len; i++) q1.push_back($urandom_range(0, 15)); end
      if (mask == 3) begin
        first = (last_model == 1) ? 0 : 1;
        order.push_back(first);
        order.push_back(1 - first);
      end else begin
        order.push_back((mask == 1) ? 0 : 1);
      end
      idx0 = 0; idx1 = 0; cyc = 0;
      while (order.size() > 0 && cyc < 400) begin
        @(negedge clk);
        if (idx0 < q0.size()) begin
          req0_valid = (idx0 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          req0_data = 4'(q0[idx0]); req0_last = (idx0 == q0.size() - 1);
        end else begin
          req0_valid = 1'b0; req0_data = 4'($urandom); req0_last = 1'($urandom);
        end
        if (idx1 < q1.size()) begin
          req1_valid = (idx1 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          req1_data = 4'(q1[idx1]); req1_last = (idx1 == q1.size() - 1);
        end else begin
          req1_valid = 1'b0; req1_data = 4'($urandom); req1_last = 1'($urandom);
        end
        res_ready = 1'($urandom_range(0, 1));
        #1;
        if (req0_ready) begin
          tests++;
          if (order.size() == 0 || order[0] != 0) begin fails++; $display("FAIL rand_owner r%0d: ready0=1 while requester 0 does not own the frame", r); end
        end
        if (req1_ready) begin
          tests++;
          if (order.size() == 0 || order[0] != 1) begin fails++; $display("FAIL rand_owner r%0d: ready1=1 while requester 1 does not own the frame", r); end
        end
        if (res_valid && res_ready) begin
          own = order.pop_front();
          tests++; if (32'(res_id) != own) begin fails++; $display("FAIL rand_id r%0d: got %0d required %0d", r, res_id, own); end
          tests++; if (32'(res_parity) != ((own == 0) ? frame_parity(q0) : frame_parity(q1))) begin
            fails++; $display("FAIL rand_parity r%0d: got %0d required %0d", r, res_parity, (own == 0) ? frame_parity(q0) : frame_parity(q1));
          end
          tests++; if (32'(res_count) != exp_count((own == 0) ? q0.size() : q1.size(), 8)) begin
            fails++; $display("FAIL rand_count r%0d: got %0d required %0d", r, res_count, exp_count((own == 0) ? q0.size() : q1.size(), 8));
          end
          last_model = own;
        end
        if (req0_valid && req0_ready) idx0++;
        if (req1_valid && req1_ready) idx1++;
        cyc++;
      end
      if (order.size() != 0) begin
        tests++; fails++;
        $display("FAIL rand_timeout r%0d: %0d results outstanding, required 0", r, order.size());
        do_reset();
        last_model = 1;
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_gap();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
